// File: rtl/temporizador_controle.sv
// temporizador_controle: microwave cooking timer with keypad entry, start/pause/clear buttons and mm:ss countdown
module temporizador_controle #(
  parameter int CLK_HZ = 100
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       comecan,
  input  logic       paren,
  input  logic       limpan,
  input  logic       portafechada,
  input  logic       tecla_valida,
  input  logic [3:0] tecla,
  output logic       m_on,
  output logic       tdone,
  output logic [3:0] min_dez,
  output logic [3:0] min_uni,
  output logic [3:0] seg_dez,
  output logic [3:0] seg_uni,
  output logic [2:0] estado
);
  typedef enum logic [2:0] {
    OCIOSO      = 3'd0,
    PROGRAMANDO = 3'd1,
    COZINHANDO  = 3'd2,
    PAUSADO     = 3'd3,
    CONCLUIDO   = 3'd4
  } est_t;
  est_t st, st_n;
  logic [15:0] t, t_n, t_dec, pre, pre_n;
  logic c_r, p_r, l_r, armed;
  logic fire_c, fire_p, fire_l, zero, tick, key_ok, borrow_s, borrow_m;
  // armed stays low for the first edge after reset so a button held through reset never fires
  assign fire_c = armed & c_r & ~comecan;
  assign fire_p = armed & p_r & ~paren;
  assign fire_l = armed & l_r & ~limpan;
  assign zero   = t == 16'd0;
  assign tick   = st == COZINHANDO && pre == 16'(CLK_HZ - 1);
  assign key_ok = tecla_valida && tecla <= 4'd9;
  // digit order in t: {min_dez, min_uni, seg_dez, seg_uni}
  assign borrow_s = t[3:0] == 4'd0;
  assign borrow_m = borrow_s && t[7:4] == 4'd0;
  assign t_dec[3:0]   = borrow_s ? 4'd9 : t[3:0] - 4'd1;
  assign t_dec[7:4]   = !borrow_s ? t[7:4] : (t[7:4] != 4'd0 ? t[7:4] - 4'd1 : 4'd5);
  assign t_dec[11:8]  = !borrow_m ? t[11:8] : (t[11:8] != 4'd0 ? t[11:8] - 4'd1 : 4'd9);
  assign t_dec[15:12] = borrow_m && t[11:8] == 4'd0 ? t[15:12] - 4'd1 : t[15:12];
  always_comb begin
    st_n = st;
    t_n  = t;
    if (fire_l) begin
      st_n = OCIOSO;
      t_n  = 16'd0;
    end else begin
      case (st)
        OCIOSO, PROGRAMANDO: begin
          if (fire_p && st == PROGRAMANDO) begin
            st_n = OCIOSO;
            t_n  = 16'd0;
          end else if (fire_c && portafechada && !zero) st_n = COZINHANDO;
          else if (key_ok) begin
            st_n = PROGRAMANDO;
            t_n  = {t[11:0], tecla};
          end
        end
        COZINHANDO: begin
          if (fire_p || !portafechada) st_n = PAUSADO;
          else if (tick) begin
            t_n  = t_dec;
            st_n = t_dec == 16'd0 ? CONCLUIDO : COZINHANDO;
          end
        end
        PAUSADO: begin
          if (fire_p) begin
            st_n = OCIOSO;
            t_n  = 16'd0;
          end else if (fire_c && portafechada && !zero) st_n = COZINHANDO;
        end
        CONCLUIDO: st_n = portafechada ? CONCLUIDO : OCIOSO;
        default: begin
          st_n = OCIOSO;
          t_n  = 16'd0;
        end
      endcase
    end
    // counting only continues while staying in COZINHANDO; entry and every other state see 0
    pre_n = (st == COZINHANDO && st_n == COZINHANDO && !tick) ? pre + 16'd1 : 16'd0;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      st    <= OCIOSO;
      t     <= 16'd0;
      pre   <= 16'd0;
      c_r   <= 1'b1;
      p_r   <= 1'b1;
      l_r   <= 1'b1;
      armed <= 1'b0;
    end else begin
      st    <= st_n;
      t     <= t_n;
      pre   <= pre_n;
      c_r   <= comecan;
      p_r   <= paren;
      l_r   <= limpan;
      armed <= 1'b1;
    end
  end
  assign m_on    = st == COZINHANDO && portafechada;
  assign tdone   = st == CONCLUIDO;
  assign estado  = st;
  assign min_dez = t[15:12];
  assign min_uni = t[11:8];
  assign seg_dez = t[7:4];
  assign seg_uni = t[3:0];
endmodule

// File: tb/tb_temporizador_controle.sv
// tb_temporizador_controle: directed scoreboard bench for temporizador_controle at CLK_HZ=4
module tb_temporizador_controle;
  logic clk = 1'b0;
  logic resetn, comecan, paren, limpan, portafechada, tecla_valida;
  logic [3:0] tecla;
  logic m_on, tdone;
  logic [3:0] min_dez, min_uni, seg_dez, seg_uni;
  logic [2:0] estado;
  int checks = 0;
  int failures = 0;
  typedef struct {
    string tag;
    logic [20:0] v;
  } exp_t;
  exp_t q[$];
  temporizador_controle #(.CLK_HZ(4)) dut (
    .clk(clk), .resetn(resetn), .comecan(comecan), .paren(paren), .limpan(limpan),
    .portafechada(portafechada), .tecla_valida(tecla_valida), .tecla(tecla),
    .m_on(m_on), .tdone(tdone), .min_dez(min_dez), .min_uni(min_uni),
    .seg_dez(seg_dez), .seg_uni(seg_uni), .estado(estado)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic expect_push(input string tag, input logic [2:0] e, input logic m, input logic d, input logic [15:0] t);
    exp_t x;
    x.tag = tag;
    x.v = {e, m, d, t};
    q.push_back(x);
  endtask
  task automatic compare_pop();
    exp_t x;
    logic [20:0] obs;
    x = q.pop_front();
    obs = {estado, m_on, tdone, min_dez, min_uni, seg_dez, seg_uni};
    checks++;
    assert (obs === x.v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", x.tag, obs, x.v);
    end
  endtask
  task automatic chk(input string tag, input logic [2:0] e, input logic m, input logic d, input logic [15:0] t);
    expect_push(tag, e, m, d, t);
    compare_pop();
  endtask
  task automatic key(input logic [3:0] k);
    tecla_valida = 1'b1;
    tecla = k;
    step(1);
    tecla_valida = 1'b0;
  endtask
  task automatic press_c();
    comecan = 1'b0;
    step(1);
    comecan = 1'b1;
  endtask
  task automatic press_p();
    paren = 1'b0;
    step(1);
    paren = 1'b1;
  endtask
  task automatic press_l();
    limpan = 1'b0;
    step(1);
    limpan = 1'b1;
  endtask
  initial begin
    resetn = 1'b0; comecan = 1'b1; paren = 1'b1; limpan = 1'b1;
    portafechada = 1'b1; tecla_valida = 1'b0; tecla = 4'd0;
    step(2);
    chk("reset", 3'd0, 1'b0, 1'b0, 16'h0000);
    resetn = 1'b1;
    step(1);
    key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
    chk("entry_2345", 3'd1, 1'b0, 1'b0, 16'h2345);
    key(4'd12);
    chk("key_gt9_ignored", 3'd1, 1'b0, 1'b0, 16'h2345);
    press_l();
    chk("limpan_clear", 3'd0, 1'b0, 1'b0, 16'h0000);
    step(1);
    key(4'd0); key(4'd0); key(4'd0); key(4'd2);
    press_c();
    chk("start_0002", 3'd2, 1'b1, 1'b0, 16'h0002);
    step(4);
    chk("count_0001", 3'd2, 1'b1, 1'b0, 16'h0001);
    step(4);
    chk("done_0000", 3'd4, 1'b0, 1'b1, 16'h0000);
    step(1);
    press_c();
    chk("done_ignores_start", 3'd4, 1'b0, 1'b1, 16'h0000);
    portafechada = 1'b0;
    step(1);
    chk("done_door_exit", 3'd0, 1'b0, 1'b0, 16'h0000);
    portafechada = 1'b1;
    key(4'd0); key(4'd1); key(4'd0); key(4'd0);
    press_c();
    step(4);
    chk("borrow_0100", 3'd2, 1'b1, 1'b0, 16'h0059);
    press_l();
    chk("limpan_in_cook", 3'd0, 1'b0, 1'b0, 16'h0000);
    step(1);
    key(4'd0); key(4'd0); key(4'd6); key(4'd0);
    press_c();
    chk("start_0060", 3'd2, 1'b1, 1'b0, 16'h0060);
    step(4);
    chk("borrow_0060", 3'd2, 1'b1, 1'b0, 16'h0059);
    step(2);
    portafechada = 1'b0;
    #1;
    chk("door_open_m_on", 3'd2, 1'b0, 1'b0, 16'h0059);
    step(1);
    chk("door_pause", 3'd3, 1'b0, 1'b0, 16'h0059);
    step(3);
    chk("pause_frozen", 3'd3, 1'b0, 1'b0, 16'h0059);
    portafechada = 1'b1;
    step(1);
    press_c();
    chk("resume", 3'd2, 1'b1, 1'b0, 16'h0059);
    step(4);
    chk("resume_count", 3'd2, 1'b1, 1'b0, 16'h0058);
    press_p();
    chk("paren_pause", 3'd3, 1'b0, 1'b0, 16'h0058);
    step(1);
    press_p();
    chk("paren_idle", 3'd0, 1'b0, 1'b0, 16'h0000);
    step(1);
    key(4'd0); key(4'd0); key(4'd0); key(4'd5);
    limpan = 1'b0; comecan = 1'b0;
    step(1);
    limpan = 1'b1; comecan = 1'b1;
    chk("limpan_beats_start", 3'd0, 1'b0, 1'b0, 16'h0000);
    step(1);
    press_c();
    chk("start_zero_ignored", 3'd0, 1'b0, 1'b0, 16'h0000);
    step(1);
    key(4'd3);
    portafechada = 1'b0;
    press_c();
    chk("start_door_open_ignored", 3'd1, 1'b0, 1'b0, 16'h0003);
    portafechada = 1'b1;
    step(1);
    press_c();
    step(2);
    chk("cook_before_reset", 3'd2, 1'b1, 1'b0, 16'h0003);
    resetn = 1'b0; comecan = 1'b0;
    step(1);
    chk("reset_mid_cook", 3'd0, 1'b0, 1'b0, 16'h0000);
    resetn = 1'b1;
    step(1);
    key(4'd7);
    step(2);
    chk("held_through_reset", 3'd1, 1'b0, 1'b0, 16'h0007);
    comecan = 1'b1;
    step(1);
    press_c();
    chk("start_after_release", 3'd2, 1'b1, 1'b0, 16'h0007);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
